// File: rtl/axis_pkg.sv
// Shared AXI-stream helpers: constant clog2, the size-width macro and the
// output-register source select used by axis_fifo and later stream blocks.
`ifndef AXIS_PKG_SV
`define AXIS_PKG_SV

`define AXIS_SWIDTH(depth) (axis_pkg::clog2((depth) + 1))

package axis_pkg;

  // Never returns less than 1 so single-entry structures still get a real index bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic [1:0] {
    OUT_HOLD     = 2'd0,
    OUT_BYPASS   = 2'd1,
    OUT_FROM_RAM = 2'd2
  } outSel_e;

endpackage

`endif

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for axis_fifo: synchronous write, asynchronous read,
// no reset so it maps onto distributed RAM.
module axis_fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int WORDS  = 3,
  parameter int AWIDTH = 2
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [WORDS];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo.sv
// DEPTH-entry AXI-stream FIFO with a registered head word and registered flags.
// Optional synchronous flush port enabled by defining AXIS_FIFO_FLUSH_EN.
module axis_fifo
  import axis_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           resetn,
`ifdef AXIS_FIFO_FLUSH_EN
  input  logic                           flush,
`endif
  output logic [`AXIS_SWIDTH(DEPTH)-1:0] size,
  input  logic [WIDTH-1:0]               idata,
  input  logic                           ivalid,
  output logic                           iready,
  output logic [WIDTH-1:0]               odata,
  output logic                           ovalid,
  input  logic                           oready
);

  localparam int SWIDTH   = `AXIS_SWIDTH(DEPTH);
  localparam int RAMWORDS = DEPTH - 1;
  localparam int PWIDTH   = clog2(RAMWORDS);

  logic [SWIDTH-1:0] size_q, size_d;
  logic              ovalid_q, ovalid_d;
  logic              iready_q, iready_d;
  logic [WIDTH-1:0]  odata_q;
  logic [PWIDTH-1:0] wp_q, wp_d;
  logic [PWIDTH-1:0] rp_q, rp_d;
  logic              push, pop, ramEmpty, ramWe;
  logic [WIDTH-1:0]  ramRdata;
  outSel_e           outSel;

  // RAM depth need not be a power of two, so wrap by compare instead of masking.
  function automatic logic [PWIDTH-1:0] ptrNext(input logic [PWIDTH-1:0] p);
    return (int'(p) == RAMWORDS - 1) ? '0 : p + PWIDTH'(1);
  endfunction

  axis_fifo_ram #(
    .WIDTH (WIDTH),
    .WORDS (RAMWORDS),
    .AWIDTH(PWIDTH)
  ) uRam (
    .clock  (clock),
    .we_i   (ramWe),
    .waddr_i(wp_q),
    .wdata_i(idata),
    .raddr_i(rp_q),
    .rdata_o(ramRdata)
  );

  always_comb begin
    push     = ivalid && iready_q;
    pop      = ovalid_q && oready;
    ramEmpty = (size_q <= SWIDTH'(1));
    outSel   = OUT_HOLD;
    ramWe    = 1'b0;
    wp_d     = wp_q;
    rp_d     = rp_q;
    size_d   = size_q + SWIDTH'(push) - SWIDTH'(pop);

    // Head slot is free this edge: an incoming word goes straight to odata.
    if (!ovalid_q || (pop && ramEmpty)) begin
      if (push) begin
        outSel = OUT_BYPASS;
      end
    end else begin
      if (pop) begin
        outSel = OUT_FROM_RAM;
        rp_d   = ptrNext(rp_q);
      end
      if (push) begin
        ramWe = 1'b1;
        wp_d  = ptrNext(wp_q);
      end
    end

`ifdef AXIS_FIFO_FLUSH_EN
    if (flush) begin
      outSel = OUT_HOLD;
      ramWe  = 1'b0;
      wp_d   = '0;
      rp_d   = '0;
      size_d = '0;
    end
`endif

    iready_d = (size_d < SWIDTH'(DEPTH));
    ovalid_d = (size_d != '0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      size_q   <= '0;
      ovalid_q <= 1'b0;
      iready_q <= 1'b1;
      wp_q     <= '0;
      rp_q     <= '0;
    end else begin
      size_q   <= size_d;
      ovalid_q <= ovalid_d;
      iready_q <= iready_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
    end
  end

  always_ff @(posedge clock) begin
    case (outSel)
      OUT_BYPASS:   odata_q <= idata;
      OUT_FROM_RAM: odata_q <= ramRdata;
      default:      ;
    endcase
  end

  assign size   = size_q;
  assign ovalid = ovalid_q;
  assign iready = iready_q;
  assign odata  = odata_q;

`ifdef FORMAL
  always_comb begin
    if (resetn) begin
      assert (size_q <= SWIDTH'(DEPTH));
      assert (iready_q == (size_q < SWIDTH'(DEPTH)));
      assert (ovalid_q == (size_q != '0));
    end
  end
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo: DEPTH 3/4/5 instances share stimulus and are
// each checked every cycle against a queue model; directed literals target DEPTH=4.
module tb_axis_fifo;

  localparam int W     = 8;
  localparam int NINST = 3;

  logic         clock = 1'b0;
  logic         resetn;
  logic [W-1:0] idata;
  logic         ivalid;
  logic         oready;
`ifdef AXIS_FIFO_FLUSH_EN
  logic         flush;
`endif

  int checks = 0;
  int errors = 0;

  logic [2:0]   sizeW   [NINST];
  logic [W-1:0] odataW  [NINST];
  logic         ovalidW [NINST];
  logic         ireadyW [NINST];

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [W-1:0] d, input logic rd);
    ivalid = iv;
    idata  = d;
    oready = rd;
    @(posedge clock);
    #1;
  endtask

  for (genvar g = 0; g < NINST; g++) begin : gInst
    localparam int D  = 3 + g;
    localparam int SW = $clog2(D + 1);

    logic [SW-1:0] sz;
    logic [W-1:0]  od;
    logic          ov;
    logic          ir;
    logic [W-1:0]  model [$];
    bit            doPush;
    bit            doPop;

    axis_fifo #(
      .WIDTH(W),
      .DEPTH(D)
    ) uDut (
      .clock (clock),
      .resetn(resetn),
`ifdef AXIS_FIFO_FLUSH_EN
      .flush (flush),
`endif
      .size  (sz),
      .idata (idata),
      .ivalid(ivalid),
      .iready(ir),
      .odata (od),
      .ovalid(ov),
      .oready(oready)
    );

    assign sizeW[g]   = 3'(sz);
    assign odataW[g]  = od;
    assign ovalidW[g] = ov;
    assign ireadyW[g] = ir;

    // Reference: a plain queue; acceptance decided by its own occupancy.
    always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        model.delete();
      end else begin
        doPush = ivalid && (model.size() < D);
        doPop  = oready && (model.size() != 0);
`ifdef AXIS_FIFO_FLUSH_EN
        if (flush) begin
          doPush = 1'b0;
          doPop  = 1'b0;
          model.delete();
        end
`endif
        if (doPop) void'(model.pop_front());
        if (doPush) model.push_back(idata);
      end
    end

    always @(negedge clock) begin
      checkOutput($sformatf("size[D=%0d]", D), int'(sz), model.size());
      checkOutput($sformatf("ovalid[D=%0d]", D), int'(ov), (model.size() != 0) ? 1 : 0);
      checkOutput($sformatf("iready[D=%0d]", D), int'(ir), (model.size() < D) ? 1 : 0);
      if (model.size() != 0) begin
        checkOutput($sformatf("odata[D=%0d]", D), int'(od), int'(model[0]));
      end
    end
  end

  initial begin
    logic iv, rd;
    resetn = 1'b0;
    ivalid = 1'b0;
    oready = 1'b0;
    idata  = '0;
`ifdef AXIS_FIFO_FLUSH_EN
    flush  = 1'b0;
`endif
    #12;
    checkOutput("reset size", int'(sizeW[1]), 0);
    checkOutput("reset ovalid", int'(ovalidW[1]), 0);
    checkOutput("reset iready", int'(ireadyW[1]), 1);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("idle size", int'(sizeW[1]), 0);
    checkOutput("idle ovalid", int'(ovalidW[1]), 0);

    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("single ovalid", int'(ovalidW[1]), 1);
    checkOutput("single odata", int'(odataW[1]), 8'hA5);
    checkOutput("single size", int'(sizeW[1]), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("single pop size", int'(sizeW[1]), 0);
    checkOutput("single pop ovalid", int'(ovalidW[1]), 0);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, W'(i), 1'b0);
      checkOutput("fill size", int'(sizeW[1]), (i < 4) ? i : 4);
      checkOutput("fill iready", int'(ireadyW[1]), (i < 4) ? 1 : 0);
    end
    checkOutput("full head", int'(odataW[1]), 1);

    for (int i = 0; i < 4; i++) begin
      checkOutput("drain odata", int'(odataW[1]), i + 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain size", int'(sizeW[1]), 3 - i);
      if (i == 0) checkOutput("drain iready", int'(ireadyW[1]), 1);
    end
    checkOutput("drain ovalid", int'(ovalidW[1]), 0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    applyStimulus(1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, W'(8'h12 + i), 1'b1);
      checkOutput("stream odata", int'(odataW[1]), 8'h11 + i);
      for (int g = 0; g < NINST; g++) begin
        checkOutput($sformatf("stream size[%0d]", g), int'(sizeW[g]), 2);
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);

`ifdef AXIS_FIFO_FLUSH_EN
    applyStimulus(1'b1, 8'h30, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b0);
    flush = 1'b1;
    applyStimulus(1'b1, 8'h32, 1'b1);
    flush = 1'b0;
    checkOutput("flush size", int'(sizeW[1]), 0);
    checkOutput("flush ovalid", int'(ovalidW[1]), 0);
    checkOutput("flush iready", int'(ireadyW[1]), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
`endif

    for (int c = 0; c < 10000; c++) begin
      if (c >= 4990 && c < 5000) begin
        iv = 1'b1;
        rd = 1'b0;
      end else begin
        iv = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
      end
`ifdef AXIS_FIFO_FLUSH_EN
      flush = (c < 4990 || c >= 5000) && ($urandom_range(0, 63) == 0);
`endif
      if (c == 5000) begin
        #2;
        resetn = 1'b0;
        #1;
        for (int g = 0; g < NINST; g++) begin
          checkOutput($sformatf("async reset size[%0d]", g), int'(sizeW[g]), 0);
          checkOutput($sformatf("async reset ovalid[%0d]", g), int'(ovalidW[g]), 0);
          checkOutput($sformatf("async reset iready[%0d]", g), int'(ireadyW[g]), 1);
        end
        @(negedge clock);
        resetn = 1'b1;
      end
      applyStimulus(iv, W'($urandom), rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
